// File: rtl/sha256_round_engine.sv
// rtl/sha256_round_engine.sv - iterative SHA-256 round engine with on-the-fly schedule and ready/valid handshakes
module sha256_round_engine #(
  parameter int ROUNDS     = 64,
  parameter int ROUND_BASE = 0,
  parameter int FEED_FWD   = 1,
  parameter int SIDE_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [255:0]      state_in,
  input  logic [511:0]      win_in,
  input  logic [255:0]      hin,
  input  logic [SIDE_W-1:0] side_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [255:0]      state_out,
  output logic [511:0]      win_out,
  output logic [255:0]      hout,
  output logic [SIDE_W-1:0] side_out,
  output logic              busy
);

  if (ROUNDS < 1 || ROUNDS > 64 || ROUND_BASE < 0 || ROUND_BASE + ROUNDS > 64) begin : g_bad_params
    $error("sha256_round_engine: ROUNDS/ROUND_BASE out of range");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [5:0]        cnt_q;
  logic [255:0]      work_q, work_d;
  logic [511:0]      win_q, win_d;
  logic [255:0]      hin_q;
  logic [SIDE_W-1:0] side_q;
  logic [255:0]      state_out_q, ff_out;
  logic [511:0]      win_out_q;
  logic [255:0]      hout_q;
  logic [SIDE_W-1:0] side_out_q;

  logic [31:0] a, b, c, d, e, f, g, h, t1, t2, w_new;
  logic [5:0]  kidx;
  logic        last;

  assign last = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid)  fsm_d = RUN;
      RUN:     if (last)      fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // One compression round plus one schedule step, both from the pre-update registers.
  always_comb begin
    {a, b, c, d, e, f, g, h} = work_q;
    kidx   = 6'(ROUND_BASE) + cnt_q;
    t1     = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[kidx] + win_q[31:0];
    t2     = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    work_d = {t1 + t2, a, b, c, d + t1, e, f, g};
    w_new  = (rotr(win_q[479:448], 17) ^ rotr(win_q[479:448], 19) ^ (win_q[479:448] >> 10))
           + win_q[319:288]
           + (rotr(win_q[63:32], 7) ^ rotr(win_q[63:32], 18) ^ (win_q[63:32] >> 3))
           + win_q[31:0];
    win_d  = {w_new, win_q[511:32]};
    ff_out = work_d;
    if (FEED_FWD != 0) begin
      for (int i = 0; i < 8; i++) ff_out[32*i +: 32] = work_d[32*i +: 32] + hin_q[32*i +: 32];
    end
  end

  // Outputs load only on the final round so they stay frozen through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      state_out_q <= '0;
      win_out_q   <= '0;
      hout_q      <= '0;
      side_out_q  <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid) begin
          cnt_q  <= '0;
          work_q <= state_in;
          win_q  <= win_in;
          hin_q  <= hin;
          side_q <= side_in;
        end
        RUN: begin
          cnt_q  <= cnt_q + 6'd1;
          work_q <= work_d;
          win_q  <= win_d;
          if (last) begin
            state_out_q <= ff_out;
            win_out_q   <= win_d;
            hout_q      <= hin_q;
            side_out_q  <= side_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign state_out = state_out_q;
  assign win_out   = win_out_q;
  assign hout      = hout_q;
  assign side_out  = side_out_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb/tb_sha256_round_engine.sv - directed bench for sha256_round_engine in several configurations
module tb_sha256_round_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] IV     = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] ABC_WIN = {32'h00000018, 448'h0, 32'h61626380};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // 64-round engine
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [255:0] a_state_in, a_hin, a_state_out, a_hout;
  logic [511:0] a_win_in, a_win_out;
  logic [31:0]  a_side_in, a_side_out;

  sha256_round_engine #(.ROUNDS(64), .ROUND_BASE(0), .FEED_FWD(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .state_in(a_state_in), .win_in(a_win_in), .hin(a_hin), .side_in(a_side_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .state_out(a_state_out),
    .win_out(a_win_out), .hout(a_hout), .side_out(a_side_out), .busy(a_busy));

  // Two chained 32-round halves
  logic c0_in_valid, c0_in_ready, c0_out_valid, c1_in_ready, c1_out_valid, c1_out_ready, c0_busy, c1_busy;
  logic [255:0] c0_state_in, c0_hin, c0_state_out, c0_hout, c1_state_out, c1_hout;
  logic [511:0] c0_win_in, c0_win_out, c1_win_out;
  logic [31:0]  c0_side_in, c0_side_out, c1_side_out;

  sha256_round_engine #(.ROUNDS(32), .ROUND_BASE(0), .FEED_FWD(0)) u_c0 (
    .clk(clk), .reset(reset), .in_valid(c0_in_valid), .in_ready(c0_in_ready),
    .state_in(c0_state_in), .win_in(c0_win_in), .hin(c0_hin), .side_in(c0_side_in),
    .out_valid(c0_out_valid), .out_ready(c1_in_ready), .state_out(c0_state_out),
    .win_out(c0_win_out), .hout(c0_hout), .side_out(c0_side_out), .busy(c0_busy));

  sha256_round_engine #(.ROUNDS(32), .ROUND_BASE(32), .FEED_FWD(1)) u_c1 (
    .clk(clk), .reset(reset), .in_valid(c0_out_valid), .in_ready(c1_in_ready),
    .state_in(c0_state_out), .win_in(c0_win_out), .hin(c0_hout), .side_in(c0_side_out),
    .out_valid(c1_out_valid), .out_ready(c1_out_ready), .state_out(c1_state_out),
    .win_out(c1_win_out), .hout(c1_hout), .side_out(c1_side_out), .busy(c1_busy));

  // 4-round engine
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [255:0] b_state_in, b_hin, b_state_out, b_hout;
  logic [511:0] b_win_in, b_win_out;
  logic [31:0]  b_side_in, b_side_out;

  sha256_round_engine #(.ROUNDS(4), .ROUND_BASE(0), .FEED_FWD(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .state_in(b_state_in), .win_in(b_win_in), .hin(b_hin), .side_in(b_side_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .state_out(b_state_out),
    .win_out(b_win_out), .hout(b_hout), .side_out(b_side_out), .busy(b_busy));

  // 16-round engine without feed-forward
  logic d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [255:0] d_state_in, d_hin, d_state_out, d_hout;
  logic [511:0] d_win_in, d_win_out;
  logic [31:0]  d_side_in, d_side_out;

  sha256_round_engine #(.ROUNDS(16), .ROUND_BASE(0), .FEED_FWD(0)) u_d (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .state_in(d_state_in), .win_in(d_win_in), .hin(d_hin), .side_in(d_side_in),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .state_out(d_state_out),
    .win_out(d_win_out), .hout(d_hout), .side_out(d_side_out), .busy(d_busy));

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Golden model: full message schedule array, then plain round loop.
  task automatic model(input logic [255:0] st, input logic [511:0] win, input logic [255:0] h,
                       input int base, input int n, input bit ff,
                       output logic [255:0] so, output logic [511:0] wo);
    logic [31:0] w [0:79];
    logic [31:0] v [0:7];
    logic [31:0] t1, t2;
    for (int j = 0; j < 80; j++) w[j] = '0;
    for (int j = 0; j < 16; j++) w[base+j] = win[32*j +: 32];
    for (int t = base + 16; t < base + n + 16; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = st[224-32*i +: 32];
    for (int t = base; t < base + n; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) so[224-32*i +: 32] = v[i] + (ff ? h[224-32*i +: 32] : 32'd0);
    for (int j = 0; j < 16; j++) wo[32*j +: 32] = w[base+n+j];
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(input int k);
    b_state_in = IV ^ {8{32'(k) * 32'h9e3779b9}};
    b_hin      = ~IV ^ {8{32'(k)}};
    b_side_in  = 32'hc0de0000 + 32'(k);
    for (int j = 0; j < 16; j++) b_win_in[32*j +: 32] = 32'h243f6a88 * 32'(j + 1) + 32'(k) * 32'h01000193;
  endtask

  task automatic abc_on_a(input string tag);
    int n;
    a_state_in = IV; a_hin = IV; a_win_in = ABC_WIN; a_side_in = 32'h00001234;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check({tag, "_busy"}, 512'(a_busy), 512'(1));
    n = 1;
    while (!a_out_valid && n < 200) begin tick(); n++; end
    check({tag, "_latency"}, 512'(n), 512'(65));
    check({tag, "_digest"}, 512'(a_state_out), 512'(DIGEST));
    check({tag, "_hout"}, 512'(a_hout), 512'(IV));
    check({tag, "_side"}, 512'(a_side_out), 512'(32'h00001234));
    tick();
    check({tag, "_idle_ready"}, 512'(a_in_ready), 512'(1));
    check({tag, "_held"}, 512'(a_state_out), 512'(DIGEST));
  endtask

  initial begin
    int n, cyc, na, no;
    int acc [3];
    int ov [3];
    logic [255:0] es, es_a;
    logic [511:0] ew, ew_a;
    logic [255:0] exps [3];
    logic [511:0] expw [3];

    reset = 1'b1;
    {a_in_valid, a_out_ready, c0_in_valid, c1_out_ready, b_in_valid, b_out_ready, d_in_valid, d_out_ready} = '0;
    {a_state_in, a_hin, c0_state_in, c0_hin, b_state_in, b_hin, d_state_in, d_hin} = '0;
    {a_win_in, c0_win_in, b_win_in, d_win_in} = '0;
    {a_side_in, c0_side_in, b_side_in, d_side_in} = '0;
    tick();
    tick();
    check("rst_in_ready", 512'(a_in_ready), 512'(1));
    check("rst_out_valid", 512'(a_out_valid), 512'(0));
    check("rst_busy", 512'(a_busy), 512'(0));
    check("rst_state_out", 512'(a_state_out), 512'(0));
    check("rst_win_out", a_win_out, 512'(0));
    check("rst_hout", 512'(a_hout), 512'(0));
    check("rst_side_out", 512'(a_side_out), 512'(0));
    reset = 1'b0;

    a_out_ready = 1'b1;
    abc_on_a("abc64");

    // abort at round 20
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (20) tick();
    check("midrun_busy", 512'(a_busy), 512'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_in_ready", 512'(a_in_ready), 512'(1));
    check("mrst_out_valid", 512'(a_out_valid), 512'(0));
    check("mrst_busy", 512'(a_busy), 512'(0));
    check("mrst_state_out", 512'(a_state_out), 512'(0));
    check("mrst_win_out", a_win_out, 512'(0));
    check("mrst_hout", 512'(a_hout), 512'(0));
    check("mrst_side_out", 512'(a_side_out), 512'(0));
    abc_on_a("abc64_after_rst");

    // chained 2x32
    c1_out_ready = 1'b1;
    c0_state_in = IV; c0_hin = IV; c0_win_in = ABC_WIN; c0_side_in = 32'hdeadbeef;
    c0_in_valid = 1'b1;
    tick();
    c0_in_valid = 1'b0;
    n = 1;
    while (!c1_out_valid && n < 300) begin tick(); n++; end
    check("chain_latency", 512'(n), 512'(66));
    check("chain_digest", 512'(c1_state_out), 512'(DIGEST));
    check("chain_side", 512'(c1_side_out), 512'(32'hdeadbeef));
    check("chain_hout", 512'(c1_hout), 512'(IV));

    // 16 rounds, raw state and schedule window
    d_out_ready = 1'b1;
    d_state_in = IV; d_hin = IV; d_win_in = ABC_WIN; d_side_in = 32'h5;
    model(IV, ABC_WIN, IV, 0, 16, 1'b0, es, ew);
    d_in_valid = 1'b1;
    tick();
    d_in_valid = 1'b0;
    n = 1;
    while (!d_out_valid && n < 100) begin tick(); n++; end
    check("r16_latency", 512'(n), 512'(17));
    check("r16_state_raw", 512'(d_state_out), 512'(es));
    check("r16_win_out", d_win_out, ew);
    check("r16_w16", 512'(d_win_out[31:0]), 512'(32'h61626380));
    check("r16_w17", 512'(d_win_out[63:32]), 512'(32'h000f0000));

    // backpressure with a second block offered during DONE
    b_out_ready = 1'b0;
    set_b(1);
    model(b_state_in, b_win_in, b_hin, 0, 4, 1'b1, es_a, ew_a);
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 50) begin tick(); n++; end
    check("bp_latency", 512'(n), 512'(5));
    check("bp_state_a", 512'(b_state_out), 512'(es_a));
    check("bp_win_a", b_win_out, ew_a);
    set_b(2);
    model(b_state_in, b_win_in, b_hin, 0, 4, 1'b1, es, ew);
    b_in_valid = 1'b1;
    repeat (10) begin
      tick();
      check("bp_in_ready_low", 512'(b_in_ready), 512'(0));
      check("bp_out_valid_held", 512'(b_out_valid), 512'(1));
      check("bp_state_stable", 512'(b_state_out), 512'(es_a));
      check("bp_win_stable", b_win_out, ew_a);
      check("bp_side_stable", 512'(b_side_out), 512'(32'hc0de0001));
    end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check("bp_idle_after_done", 512'(b_in_ready), 512'(1));
    tick();
    b_in_valid = 1'b0;
    check("bp_second_accepted", 512'(b_busy), 512'(1));
    n = 1;
    while (!b_out_valid && n < 50) begin tick(); n++; end
    check("bp_latency_b", 512'(n), 512'(5));
    check("bp_state_b", 512'(b_state_out), 512'(es));
    check("bp_win_b", b_win_out, ew);
    check("bp_side_b", 512'(b_side_out), 512'(32'hc0de0002));
    b_out_ready = 1'b1;
    tick();

    // back-to-back throughput
    for (int k = 0; k < 3; k++) begin
      set_b(3 + k);
      model(b_state_in, b_win_in, b_hin, 0, 4, 1'b1, exps[k], expw[k]);
      acc[k] = 0;
      ov[k] = 0;
    end
    set_b(3);
    b_in_valid = 1'b1;
    cyc = 0; na = 0; no = 0;
    for (int i = 0; i < 40; i++) begin
      automatic logic hs = b_in_ready && b_in_valid;
      tick();
      cyc++;
      if (hs && na < 3) begin
        acc[na] = cyc - 1;
        na++;
        if (na < 3) set_b(3 + na);
        else b_in_valid = 1'b0;
      end
      if (b_out_valid && no < 3) begin
        ov[no] = cyc;
        check("tp_state", 512'(b_state_out), 512'(exps[no]));
        check("tp_win", b_win_out, expw[no]);
        no++;
      end
    end
    check("tp_accepts", 512'(na), 512'(3));
    check("tp_results", 512'(no), 512'(3));
    check("tp_period_01", 512'(acc[1] - acc[0]), 512'(6));
    check("tp_period_12", 512'(acc[2] - acc[1]), 512'(6));
    for (int k = 0; k < 3; k++) check("tp_latency", 512'(ov[k] - acc[k]), 512'(5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_engine.md
# sha256_round_engine

Parametrised, iterative SHA-256 compression engine that executes `ROUNDS` consecutive rounds, starting at round index `ROUND_BASE`, at one round per clock. It is the next generation of the fixed-depth round stage used in the bitcoin miner pipeline. Unlike that stage, it holds the round constants internally, expands the message schedule on the fly from a 16-word sliding window, performs an optional final Davies–Meyer feed-forward, and moves data over ready/valid handshakes on both sides. Several instances can be chained (e.g. 2×32 or 4×16 rounds) to trade area for throughput.

## Interface
- `ROUNDS`, default 64: rounds executed per accepted block; range 1..64.
- `ROUND_BASE`, default 0: index of the first round (selects `K[ROUND_BASE]`). `ROUND_BASE+ROUNDS<=64`; any violation is an elaboration error.
- `FEED_FWD`, default 1: 1 means `state_out` = final state + `hin` (per word, mod 2^32); 0 means the raw final state.
- `SIDE_W`, default 32: width of the sideband (e.g. nonce) carried alongside the block.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input block valid.
- `in_ready`  out  1  engine can accept a block.
- `state_in`  in  256  working state {a,b,c,d,e,f,g,h}; a in [255:224].
- `win_in`  in  512  schedule window; word j in [32j+:32] is `W[ROUND_BASE+j]`.
- `hin`  in  256  chaining value, same word order as `state_in`; passed through.
- `side_in`  in  SIDE_W  sideband; passed through unchanged.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `state_out`  out  256  result state, ordered as `state_in`.
- `win_out`  out  512  window after `ROUNDS` shifts (`W[ROUND_BASE+ROUNDS+j]`).
- `hout`  out  256  registered copy of `hin`.
- `side_out`  out  SIDE_W  registered copy of `side_in`.
- `busy`  out  1  FSM not in IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DONE. `in_ready = (fsm==IDLE)`. `out_valid = (fsm==DONE)`.
- **IDLE:** when `in_valid&&in_ready`, latch `state_in`, `win_in`, `hin` and `side_in`; set round counter to 0; go to RUN. Nothing else changes.
- **RUN:** each cycle performs one round with `Wt = window word 0` and `Kt = K[ROUND_BASE+counter]` (standard FIPS 180-4 table, internal ROM).
  - T1 = h+Σ1(e)+Ch(e,f,g)+Kt+Wt.
  - T2 = Σ0(a)+Maj(a,b,c).
  - Update: a←T1+T2, e←d+T1, and b..d and f..h shift as usual. All sums are mod 2^32.
- **Window update (RUN):** the window shifts down one word. Word 15 ← σ1(w14)+w9+σ0(w1)+w0, computed from the pre-shift window. Words beyond round 63 are still computed deterministically and are unused.
- **Counter (RUN):** the counter increments each round. When `counter==ROUNDS-1`, that round completes and the FSM goes to DONE. The transition registers `state_out` (feed-forward applied if `FEED_FWD`) and `win_out`.
- **DONE:** all outputs are held stable while `out_valid&&!out_ready`. When `out_valid&&out_ready`, go to IDLE.
- Inputs are ignored outside IDLE. `in_valid` seen in RUN or DONE has no effect.
- **Reset:** FSM→IDLE, counter→0, and every output register zeroed. Resulting output values: `in_ready=1`, `out_valid=0`, `busy=0`, and `state_out`, `win_out`, `hout`, `side_out` all 0.
- **Reset mid-RUN or in DONE:** the block is aborted with no output.

## Timing
- **Latency:** handshake in cycle T gives `out_valid` high in cycle T+ROUNDS+1.
- **Throughput:** with `out_ready` held high, one block every ROUNDS+2 cycles (DONE handshake cycle, then IDLE accept cycle).
- **`ROUNDS=1`:** exactly one RUN cycle; same latency rule.
- **Output changes:** outputs change only on the RUN→DONE edge and on reset.

## Test plan
- **"abc" single block:** `ROUNDS=64`, `ROUND_BASE=0`, `FEED_FWD=1`, `hin=state_in=IV`, `win_in` word0=0x61626380, word15=0x00000018, all others 0 → `state_out`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; `out_valid` in cycle T+65.
- **Chained instances:** inst0 (`ROUNDS=32`, `ROUND_BASE=0`, `FEED_FWD=0`) feeds inst1 (`ROUNDS=32`, `ROUND_BASE=32`, `FEED_FWD=1`) with state, window, `hout` and `side` forwarded, and the "abc" vectors applied → same digest; `side_in`=0xDEADBEEF appears on inst1 `side_out`.
- **Backpressure:** `ROUNDS=4`, `out_ready` low for 10 cycles after `out_valid` → `state_out`/`win_out`/`side_out` stable; `in_ready=0` and a second `in_valid` ignored; after `out_ready` rises, IDLE follows and the second block is accepted, with its result matching a golden model.
- **Latency/throughput:** `ROUNDS=4`, `out_ready`=1, back-to-back valid blocks → accepts every 6 cycles; each `out_valid` exactly 5 cycles after its accept; results match a C model of rounds 0–3.
- **Reset mid-operation:** assert `reset` at round 20 of a 64-round run → next cycle `in_ready=1`, `out_valid=0`, all outputs 0; a subsequent "abc" block still gives the correct digest.
- **`FEED_FWD=0` / `win_out` check:** `ROUNDS=16`, "abc" → `win_out` equals `W[16..31]` from the golden schedule and `state_out` equals the raw round-15 state.
